// File: rtl/image_write_pkg.sv
// image_pkg: BMP layout constants, FSM state encoding and row sizing helpers
// shared by the image reader and writer.
package image_pkg;
    localparam int BMP_HDR_BYTES = 54;
    localparam int BMP_DIB_SIZE  = 40;
    localparam int BMP_BPP       = 24;

    typedef enum logic [1:0] {
        ST_CAPTURE,
        ST_HEADER,
        ST_DATA,
        ST_DONE
    } state_t;

    function automatic int row_pad(input int width);
        return (4 - (width * 3) % 4) % 4;
    endfunction

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/image_write_if.sv
// image_write_if: pixel input strobe plus the BMP byte valid/ready stream.
interface image_write_if;
    logic       HSYNC;
    logic [7:0] DATA_R0;
    logic [7:0] DATA_G0;
    logic [7:0] DATA_B0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       frame_done;
    logic       drop_err;

    modport slave (
        input  HSYNC, DATA_R0, DATA_G0, DATA_B0, byte_ready,
        output byte_out, byte_valid, frame_done, drop_err
    );

    modport master (
        output HSYNC, DATA_R0, DATA_G0, DATA_B0, byte_ready,
        input  byte_out, byte_valid, frame_done, drop_err
    );
endinterface

// File: rtl/image_write_bmp_header_rom.sv
// bmp_header_rom: combinational 54-byte little-endian BMP/DIB header lookup.
module bmp_header_rom
    import image_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  logic [5:0] hdr_idx,
    output logic [7:0] hdr_byte
);
    localparam int ROWB  = WIDTH * 3 + row_pad(WIDTH);
    localparam int IMG   = ROWB * HEIGHT;
    localparam int FSIZE = BMP_HDR_BYTES + IMG;

    // Fields concatenated last-to-first so byte i sits at bits [8i+7:8i]
    localparam logic [8*BMP_HDR_BYTES-1:0] HDR = {
        32'd0, 32'd0, 32'd0, 32'd0, 32'(IMG), 32'd0,
        16'(BMP_BPP), 16'd1, 32'(HEIGHT), 32'(WIDTH), 32'(BMP_DIB_SIZE),
        32'(BMP_HDR_BYTES), 32'd0, 32'(FSIZE), 8'h4D, 8'h42
    };

    always_comb hdr_byte = (hdr_idx < 6'(BMP_HDR_BYTES)) ? HDR[{hdr_idx, 3'b000} +: 8] : 8'h00;
endmodule

// File: rtl/image_write.sv
// image_write: captures one RGB888 frame and streams it out as a 24-bit BMP.
module image_write
    import image_pkg::*;
#(
    parameter int    WIDTH   = 768,
    parameter int    HEIGHT  = 512,
    parameter string OUTFILE = "output.bmp"
) (
    input logic          HCLK,
    input logic          HRESETn,
    image_write_if.slave bus
);
    localparam int PAD  = row_pad(WIDTH);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int AW   = cw(NPIX);
    localparam int CW   = cw(WIDTH + 1);
    localparam int RW   = cw(HEIGHT);

    state_t          r_state, w_next;
    logic [CW-1:0]   r_ccol, r_dcol;
    logic [RW-1:0]   r_crow, r_drow;
    logic [5:0]      r_hdr;
    logic [AW-1:0]   r_rd;
    logic [1:0]      r_sub;
    logic            r_drop;
    logic [23:0]     r_buf [NPIX];

    logic [AW-1:0]   w_waddr;
    logic [23:0]     w_pix;
    logic [7:0]      w_hdr_byte, w_data_byte, w_byte;
    logic            w_valid, w_done, w_xfer, w_cap, w_last_px;
    logic            w_in_pad, w_px_end, w_row_end, w_last_byte;

    bmp_header_rom #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_rom (
        .hdr_idx  (r_hdr),
        .hdr_byte (w_hdr_byte)
    );

    // Raster rows arrive top-first; storing them flipped makes readout a linear walk
    assign w_waddr     = AW'(WIDTH * (HEIGHT - 1 - int'(r_crow)) + int'(r_ccol));
    assign w_cap       = (r_state == ST_CAPTURE) && bus.HSYNC;
    assign w_last_px   = (r_ccol == CW'(WIDTH - 1)) && (r_crow == RW'(HEIGHT - 1));
    assign w_xfer      = w_valid && bus.byte_ready;
    assign w_pix       = r_buf[r_rd];
    assign w_in_pad    = r_dcol == CW'(WIDTH);
    assign w_px_end    = !w_in_pad && (r_sub == 2'd2);
    assign w_row_end   = w_in_pad ? (r_sub == 2'(PAD - 1)) : (w_px_end && r_dcol == CW'(WIDTH - 1) && PAD == 0);
    assign w_last_byte = w_row_end && (r_drow == RW'(HEIGHT - 1));
    assign w_data_byte = w_in_pad ? 8'h00 : (r_sub == 2'd0) ? w_pix[7:0] : (r_sub == 2'd1) ? w_pix[15:8] : w_pix[23:16];

    always_comb begin
        w_next  = r_state;
        w_valid = 1'b0;
        w_byte  = 8'h00;
        w_done  = 1'b0;
        case (r_state)
            ST_CAPTURE: w_next = (w_cap && w_last_px) ? ST_HEADER : ST_CAPTURE;
            ST_HEADER: begin
                w_valid = 1'b1;
                w_byte  = w_hdr_byte;
                w_next  = (w_xfer && r_hdr == 6'(BMP_HDR_BYTES - 1)) ? ST_DATA : ST_HEADER;
            end
            ST_DATA: begin
                w_valid = 1'b1;
                w_byte  = w_data_byte;
                w_next  = (w_xfer && w_last_byte) ? ST_DONE : ST_DATA;
            end
            default: begin
                w_done = 1'b1;
                w_next = ST_CAPTURE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_CAPTURE;
            r_ccol  <= '0;
            r_crow  <= '0;
            r_hdr   <= '0;
            r_rd    <= '0;
            r_sub   <= '0;
            r_dcol  <= '0;
            r_drow  <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_drop  <= r_drop | (bus.HSYNC && r_state != ST_CAPTURE);
            if (w_cap) begin
                r_ccol <= (r_ccol == CW'(WIDTH - 1)) ? '0 : r_ccol + 1'b1;
                if (r_ccol == CW'(WIDTH - 1))
                    r_crow <= (r_crow == RW'(HEIGHT - 1)) ? '0 : r_crow + 1'b1;
            end
            if (r_state == ST_HEADER && w_xfer)
                r_hdr <= (r_hdr == 6'(BMP_HDR_BYTES - 1)) ? '0 : r_hdr + 1'b1;
            if (r_state == ST_DATA && w_xfer) begin
                r_rd   <= w_last_byte ? '0 : w_px_end ? r_rd + 1'b1 : r_rd;
                r_sub  <= (w_row_end || w_px_end) ? '0 : r_sub + 1'b1;
                r_dcol <= w_row_end ? '0 : w_px_end ? r_dcol + 1'b1 : r_dcol;
                r_drow <= w_last_byte ? '0 : w_row_end ? r_drow + 1'b1 : r_drow;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_cap) r_buf[w_waddr] <= {bus.DATA_R0, bus.DATA_G0, bus.DATA_B0};
    end

    assign bus.byte_out   = w_byte;
    assign bus.byte_valid = w_valid;
    assign bus.frame_done = w_done;
    assign bus.drop_err   = r_drop;
endmodule
